// File: rtl/div_16bit_pkg.sv
// Shared definitions for the iterative divider: operand width, iteration count
// and the controller state encoding.
package div_16bit_pkg;

   localparam int WIDTH_DEF  = 16;
   localparam int ITER_COUNT = 16;
   localparam int CNT_W      = 5;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div_16bit_adder.sv
// Plain 16-bit ripple-carry adder; the divider uses it as the trial subtractor.
module adder_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   logic [16:0] carry;

   always_comb begin
      sum      = '0;
      carry    = '0;
      carry[0] = cin;
      for (int i = 0; i < 16; i++) begin
         sum[i]     = a[i] ^ b[i] ^ carry[i];
         carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = carry[16];

endmodule

// File: rtl/div_16bit.sv
// Unsigned 16-bit restoring divider: fixed 16-cycle run, one-cycle done pulse,
// divide-by-zero resolved immediately. Results only change on completion.
module div_16bit
   import div_16bit_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output state_t           dbg_state
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] remo_q, remo_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   partial;
   logic [WIDTH-1:0] diff_lo;
   logic             carry_lo;
   logic             trial_ok;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_sh;
   logic             accept;

   // The shifted partial remainder is 17 bits wide so divisors above 16'h8000
   // are handled; bit 16 is a full-adder cell with the inverted-zero operand (1).
   assign partial = {rem_q, sh_q[WIDTH-1]};

   adder_16bit u_sub (
      .a    (partial[WIDTH-1:0]),
      .b    (~dvs_q),
      .cin  (1'b1),
      .sum  (diff_lo),
      .cout (carry_lo)
   );

   assign trial_ok = (partial[WIDTH] & 1'b1) | (carry_lo & (partial[WIDTH] ^ 1'b1));
   assign step_rem = trial_ok ? diff_lo : partial[WIDTH-1:0];
   assign step_sh  = {sh_q[WIDTH-2:0], trial_ok};
   assign accept   = start && (state_q != ST_RUN);

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      sh_d    = sh_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      remo_d  = remo_q;
      dbz_d   = dbz_q;
      case (state_q)
         ST_RUN: begin
            rem_d = step_rem;
            sh_d  = step_sh;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
               state_d = ST_DONE;
               quo_d   = step_sh;
               remo_d  = step_rem;
            end
         end
         default: begin
            state_d = ST_IDLE;
            if (accept) begin
               rem_d = '0;
               sh_d  = dividend;
               dvs_d = divisor;
               cnt_d = '0;
               dbz_d = 1'b0;
               if (divisor == '0) begin
                  state_d = ST_DONE;
                  dbz_d   = 1'b1;
                  quo_d   = '1;
                  remo_d  = dividend;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         sh_q    <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         remo_q  <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         sh_q    <= sh_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         remo_q  <= remo_d;
         dbz_q   <= dbz_d;
      end
   end

   assign quotient    = quo_q;
   assign remainder   = remo_q;
   assign busy        = (state_q == ST_RUN);
   assign done        = (state_q == ST_DONE);
   assign div_by_zero = dbz_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_div_16bit.sv
// Directed bench for div_16bit: cycle-level reference model plus literal
// expectations for latency and results of hand-worked divisions.
module tb_div_16bit;
   import div_16bit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] dividend = '0;
   logic [15:0] divisor = '0;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   state_t      dbg_state;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   div_16bit #(.WIDTH(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: counts cycles since the accepted start; a normal divide
   // completes in cycle 17, a divide by zero in cycle 1.
   bit          m_active = 1'b0;
   int          m_cyc = 0;
   int          m_target = 17;
   logic [15:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
   logic        m_dbz = 1'b0;

   function automatic bit model_busy();
      return m_active && (m_target == 17) && (m_cyc < 17);
   endfunction

   function automatic bit model_done();
      return m_active && (m_cyc == m_target);
   endfunction

   always @(posedge clk) begin
      bit          n_active;
      int          n_cyc, n_target;
      logic [15:0] n_q, n_r, n_pq, n_pr;
      logic        n_dbz;
      n_active = m_active; n_cyc = m_cyc; n_target = m_target;
      n_q = m_q; n_r = m_r; n_pq = p_q; n_pr = p_r; n_dbz = m_dbz;
      if (!rst_n) begin
         n_active = 1'b0; n_cyc = 0; n_q = '0; n_r = '0; n_dbz = 1'b0;
      end else begin
         if (start && !model_busy()) begin
            n_active = 1'b1;
            n_cyc    = 1;
            n_dbz    = 1'b0;
            if (divisor == 16'd0) begin
               n_target = 1; n_pq = 16'hFFFF; n_pr = dividend;
            end else begin
               n_target = 17; n_pq = dividend / divisor; n_pr = dividend % divisor;
            end
         end else if (n_active) begin
            n_cyc++;
            if (n_cyc > n_target) n_active = 1'b0;
         end
         if (n_active && n_cyc == n_target) begin
            n_q = n_pq; n_r = n_pr; n_dbz = (n_target == 1);
         end
      end
      m_active <= n_active; m_cyc <= n_cyc; m_target <= n_target;
      m_q <= n_q; m_r <= n_r; p_q <= n_pq; p_r <= n_pr; m_dbz <= n_dbz;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_busy", busy, model_busy());
         check("model_done", done, model_done());
         check("model_dbz", div_by_zero, m_dbz);
         check("model_quotient", quotient, m_q);
         check("model_remainder", remainder, m_r);
         check("busy_done_exclusive", busy & done, 1'b0);
      end
   end

   // Issues an operation and waits for done. With now=1 the start is driven
   // in the current cycle (used to start inside a DONE cycle).
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit now,
                         input logic [15:0] exp_q, input logic [15:0] exp_r,
                         input logic exp_dbz, input int exp_lat, input string name);
      int lat;
      if (!now) @(negedge clk);
      start = 1'b1; dividend = a; divisor = b;
      @(negedge clk);
      start = 1'b0; dividend = 16'($urandom); divisor = 16'($urandom);
      lat = 1;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({name, "_latency"}, lat, exp_lat);
      check({name, "_quotient"}, quotient, exp_q);
      check({name, "_remainder"}, remainder, exp_r);
      check({name, "_dbz"}, div_by_zero, exp_dbz);
   endtask

   task automatic count_dones(input int cycles, input string name);
      int seen = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (done) seen++;
      end
      check(name, seen, 0);
   endtask

   initial begin
      int lat;
      start = 1'b1; dividend = 16'd9; divisor = 16'd3;
      repeat (3) @(negedge clk);
      rst_n = 1'b1; start = 1'b0;
      chk_en = 1'b1;
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_quotient", quotient, 16'h0000);
      check("reset_remainder", remainder, 16'h0000);

      run_op(16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, 17, "basic_100_7");
      run_op(16'hFFFF, 16'd1, 1'b0, 16'hFFFF, 16'd0, 1'b0, 17, "ffff_1");
      run_op(16'hFFFF, 16'hFFFF, 1'b0, 16'd1, 16'd0, 1'b0, 17, "ffff_ffff");
      run_op(16'd3, 16'd10, 1'b0, 16'd0, 16'd3, 1'b0, 17, "3_10");
      run_op(16'hFFFF, 16'h8001, 1'b0, 16'd1, 16'h7FFE, 1'b0, 17, "ffff_8001");
      run_op(16'd40000, 16'd40001, 1'b0, 16'd0, 16'd40000, 1'b0, 17, "40000_40001");
      run_op(16'd12345, 16'd123, 1'b0, 16'd100, 16'd45, 1'b0, 17, "12345_123");
      run_op(16'd32768, 16'd3, 1'b0, 16'd10922, 16'd2, 1'b0, 17, "32768_3");
      run_op(16'd65535, 16'd256, 1'b0, 16'd255, 16'd255, 1'b0, 17, "65535_256");

      run_op(16'd5, 16'd0, 1'b0, 16'hFFFF, 16'd5, 1'b1, 1, "div0_5");
      repeat (3) @(negedge clk);
      check("div0_hold_dbz", div_by_zero, 1'b1);
      check("div0_hold_quotient", quotient, 16'hFFFF);

      // start during busy is ignored
      @(negedge clk);
      start = 1'b1; dividend = 16'd100; divisor = 16'd7;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 40) begin
         if (lat == 5) begin
            start = 1'b1; dividend = 16'd9; divisor = 16'd3;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      check("ignored_latency", lat, 17);
      check("ignored_quotient", quotient, 16'd14);
      check("ignored_remainder", remainder, 16'd2);
      count_dones(20, "ignored_no_second_done");

      // back-to-back: start in the DONE cycle
      run_op(16'd1000, 16'd10, 1'b0, 16'd100, 16'd0, 1'b0, 17, "b2b_first");
      run_op(16'd50, 16'd6, 1'b1, 16'd8, 16'd2, 1'b0, 17, "b2b_second");
      @(negedge clk);
      check("b2b_done_dropped", done, 1'b0);

      // reset at cycle 8 of a run
      start = 1'b1; dividend = 16'd100; divisor = 16'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0; start = 1'b1; dividend = 16'd9; divisor = 16'd3;
      @(negedge clk);
      rst_n = 1'b1; start = 1'b0;
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_done", done, 1'b0);
      check("rst_mid_dbz", div_by_zero, 1'b0);
      check("rst_mid_quotient", quotient, 16'h0000);
      check("rst_mid_remainder", remainder, 16'h0000);
      count_dones(20, "rst_mid_no_done");

      run_op(16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, 17, "after_reset");
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
